// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order window between issue and commit; tag 0 means "no dependency".
// Optional feature macro ROB_BYPASS_EN forwards same-cycle CDB results into the rs/rt operand lookups.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             in_assign_enable,
    input  logic [5:0]       in_type,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_pc,
    input  logic             in_predict,
    input  logic             in_reg_write,
    output logic [TAG_W-1:0] out_tail,
    output logic             out_full,
    input  logic [TAG_W-1:0] in_rs_reorder,
    input  logic [TAG_W-1:0] in_rt_reorder,
    output logic             out_rs_ready,
    output logic [31:0]      out_rs_value,
    output logic             out_rt_ready,
    output logic [31:0]      out_rt_value,
    input  logic             in_alu_valid,
    input  logic [TAG_W-1:0] in_alu_reorder,
    input  logic [31:0]      in_alu_value,
    input  logic             in_alu_jump,
    input  logic [31:0]      in_alu_target,
    input  logic             in_lsb_valid,
    input  logic [TAG_W-1:0] in_lsb_reorder,
    input  logic [31:0]      in_lsb_value,
    output logic             out_commit_reg,
    output logic [4:0]       out_commit_rd,
    output logic [TAG_W-1:0] out_commit_reorder,
    output logic [31:0]      out_commit_value,
    output logic             out_commit_store,
    output logic             out_flush,
    output logic [31:0]      out_flush_pc
);

    // Operator encodings shared with the decoder: JALR, contiguous branch range, contiguous store range.
    localparam logic [5:0] OP_JALR = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd5;
    localparam logic [5:0] OP_BGEU = 6'd10;
    localparam logic [5:0] OP_SB   = 6'd16;
    localparam logic [5:0] OP_SW   = 6'd18;

    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE - 1);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        predict;
        logic        reg_write;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
    } entry_t;

    entry_t            slot_q [ROB_SIZE];
    entry_t            slot_d [ROB_SIZE];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W-1:0]  count_q, count_d;
    logic              commit_reg_q, commit_reg_d;
    logic [4:0]        commit_rd_q, commit_rd_d;
    logic [TAG_W-1:0]  commit_reorder_q, commit_reorder_d;
    logic [31:0]       commit_value_q, commit_value_d;
    logic              commit_store_q, commit_store_d;
    logic              flush_q, flush_d;
    logic [31:0]       flush_pc_q, flush_pc_d;

    entry_t head_e;
    logic   live, full, issue_en, commit_en;
    logic   head_is_store, head_is_branch, head_is_jalr;

    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
        return (tag == LAST_TAG) ? FIRST_TAG : tag + FIRST_TAG;
    endfunction

    // The cycle showing a flush pulse belongs to the squashed path, so nothing is accepted in it.
    assign live           = rdy_in & ~flush_q;
    assign full           = (count_q == LAST_TAG);
    assign head_e         = slot_q[head_q];
    assign head_is_store  = (head_e.op >= OP_SB) && (head_e.op <= OP_SW);
    assign head_is_branch = (head_e.op >= OP_BEQ) && (head_e.op <= OP_BGEU);
    assign head_is_jalr   = (head_e.op == OP_JALR);
    assign issue_en       = live & in_assign_enable & ~full;
    assign commit_en      = live & (count_q != '0) & head_e.ready;

    always_comb begin
        slot_d           = slot_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        commit_reg_d     = 1'b0;
        commit_rd_d      = '0;
        commit_reorder_d = '0;
        commit_value_d   = '0;
        commit_store_d   = 1'b0;
        flush_d          = 1'b0;
        flush_pc_d       = '0;

        if (issue_en) begin
            slot_d[tail_q] = '{busy: 1'b1, ready: 1'b0, op: in_type, rd: in_rd, pc: in_pc,
                               predict: in_predict, reg_write: in_reg_write,
                               value: 32'd0, jump: 1'b0, target: 32'd0};
            tail_d = next_tag(tail_q);
        end

        if (live && in_alu_valid && in_alu_reorder != '0) begin
            slot_d[in_alu_reorder].ready  = 1'b1;
            slot_d[in_alu_reorder].value  = in_alu_value;
            slot_d[in_alu_reorder].jump   = in_alu_jump;
            slot_d[in_alu_reorder].target = in_alu_target;
        end
        if (live && in_lsb_valid && in_lsb_reorder != '0) begin
            slot_d[in_lsb_reorder].ready = 1'b1;
            slot_d[in_lsb_reorder].value = in_lsb_value;
        end

        if (commit_en) begin
            slot_d[head_q].busy = 1'b0;
            head_d              = next_tag(head_q);
            commit_reorder_d    = head_q;
            commit_rd_d         = head_e.rd;
            commit_value_d      = head_e.value;
            commit_store_d      = head_is_store;
            commit_reg_d        = ~head_is_store & ~head_is_branch & head_e.reg_write & (head_e.rd != 5'd0);
            if (head_is_jalr || (head_is_branch && head_e.jump != head_e.predict)) begin
                flush_d    = 1'b1;
                flush_pc_d = (head_is_jalr || head_e.jump) ? head_e.target : head_e.pc + 32'd4;
            end
        end

        case ({issue_en, commit_en})
            2'b10:   count_d = count_q + FIRST_TAG;
            2'b01:   count_d = count_q - FIRST_TAG;
            default: count_d = count_q;
        endcase

        // Everything younger than a mispredicted head is wrong-path work, including this cycle's issue.
        if (flush_d) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                slot_d[i] = '0;
            end
            head_d  = FIRST_TAG;
            tail_d  = FIRST_TAG;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                slot_q[i] <= '0;
            end
            head_q           <= FIRST_TAG;
            tail_q           <= FIRST_TAG;
            count_q          <= '0;
            commit_reg_q     <= 1'b0;
            commit_rd_q      <= '0;
            commit_reorder_q <= '0;
            commit_value_q   <= '0;
            commit_store_q   <= 1'b0;
            flush_q          <= 1'b0;
            flush_pc_q       <= '0;
        end else begin
            slot_q           <= slot_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            commit_reg_q     <= commit_reg_d;
            commit_rd_q      <= commit_rd_d;
            commit_reorder_q <= commit_reorder_d;
            commit_value_q   <= commit_value_d;
            commit_store_q   <= commit_store_d;
            flush_q          <= flush_d;
            flush_pc_q       <= flush_pc_d;
        end
    end

    always_comb begin
        out_rs_ready = 1'b0;
        out_rs_value = '0;
        if (in_rs_reorder != '0) begin
            out_rs_ready = slot_q[in_rs_reorder].busy & slot_q[in_rs_reorder].ready;
            out_rs_value = slot_q[in_rs_reorder].value;
`ifdef ROB_BYPASS_EN
            if (in_alu_valid && in_alu_reorder == in_rs_reorder) begin
                out_rs_ready = 1'b1;
                out_rs_value = in_alu_value;
            end else if (in_lsb_valid && in_lsb_reorder == in_rs_reorder) begin
                out_rs_ready = 1'b1;
                out_rs_value = in_lsb_value;
            end
`endif
        end
    end

    always_comb begin
        out_rt_ready = 1'b0;
        out_rt_value = '0;
        if (in_rt_reorder != '0) begin
            out_rt_ready = slot_q[in_rt_reorder].busy & slot_q[in_rt_reorder].ready;
            out_rt_value = slot_q[in_rt_reorder].value;
`ifdef ROB_BYPASS_EN
            if (in_alu_valid && in_alu_reorder == in_rt_reorder) begin
                out_rt_ready = 1'b1;
                out_rt_value = in_alu_value;
            end else if (in_lsb_valid && in_lsb_reorder == in_rt_reorder) begin
                out_rt_ready = 1'b1;
                out_rt_value = in_lsb_value;
            end
`endif
        end
    end

    assign out_tail           = tail_q;
    assign out_full           = full;
    assign out_commit_reg     = commit_reg_q;
    assign out_commit_rd      = commit_rd_q;
    assign out_commit_reorder = commit_reorder_q;
    assign out_commit_value   = commit_value_q;
    assign out_commit_store   = commit_store_q;
    assign out_flush          = flush_q;
    assign out_flush_pc       = flush_pc_q;

endmodule
